scratchpad_arbiter: RTL and testbench
=====================================

Name: scratchpad_arbiter

Overview:
- Shares the single-port scratchpad between NREQ requesters: host controller, input-operand fetcher, weight fetcher and output writeback of the systolic array.
- Grants one access at a time using round-robin, with optional fixed priority for requester 0 (host).
- Holds the scratchpad handshake until sc_ready, then returns a one-cycle done pulse with registered read data to the granted requester.
- Watchdog aborts accesses the scratchpad never acknowledges.

Parameters:
- NREQ, 4, number of requesters; index 0 = host.
- HOST_PRIO, 1, 1 = requester 0 always wins when requesting; 0 = pure round-robin.
- TIMEOUT, 255, max ACCESS cycles without sc_ready before abort; 0 disables the watchdog.

Ports:
- clk  in  1  clock
- n_rst  in  1  asynchronous active-low reset
- req  in  NREQ  per-requester access request; held high until that requester's done
- req_we  in  NREQ  1 = write, 0 = read; valid while req high
- req_addr  in  NREQ x word_t  per-requester word address
- req_wdata  in  NREQ x word_t  per-requester write data
- grant  out  NREQ  one-hot; high for the whole ACCESS phase of the owner
- done  out  NREQ  one-hot single-cycle completion pulse
- err  out  1  qualifies done: access aborted by timeout
- rdata  out  word_t  read data, valid with done
- sc_read_en  out  1  scratchpad read strobe
- sc_write_en  out  1  scratchpad write strobe
- sc_addr  out  word_t  scratchpad address
- sc_wdata  out  word_t  scratchpad write data
- sc_rdata  in  word_t  scratchpad read data, valid with sc_ready
- sc_ready  in  1  scratchpad completion

Behaviour:
- Reset values:
  - All outputs are 0.
  - state = IDLE.
  - rr_ptr = NREQ-1, so requester 0 wins first under pure round-robin.
  - Watchdog counter = 0.
  - Latched index, addr, wdata and we = 0.
- States: IDLE, ACCESS, RESP (enum in package).
- IDLE:
  - If any req bit is high, choose the winner: requester 0 if HOST_PRIO=1 and req[0]=1; otherwise the first set bit scanning rr_ptr+1 upward, modulo NREQ.
  - Latch the winner's index, we, addr and wdata.
  - Next state = ACCESS.
  - If no req bit is high, stay in IDLE.
- ACCESS:
  - grant[idx]=1.
  - sc_read_en = !we; sc_write_en = we.
  - sc_addr and sc_wdata come from the latched values; they are stable for the whole phase and ignore later requester input changes.
  - Watchdog counter increments each cycle.
  - On sc_ready: capture sc_rdata into rdata (capture on writes too), err=0, next state = RESP.
  - Else if TIMEOUT!=0 and counter == TIMEOUT-1: rdata=0, err=1, next state = RESP.
  - sc_ready wins over timeout in the same cycle.
- RESP:
  - done[idx]=1 and err are valid for exactly one cycle; grant=0; strobes=0.
  - rr_ptr = idx. rr_ptr is not updated on a HOST_PRIO override of requester 0, so host traffic does not disturb fairness among 1..NREQ-1.
  - Counter cleared.
  - Next state = IDLE.
  - No arbitration happens in RESP; this lets the requester drop req after sampling done.
- Latency: req high in IDLE cycle t → grant and strobe at t+1 → sc_ready at cycle k → done at k+1 → earliest next grant at k+3.
- A requester keeping req high after done makes a new request.
- Requests arriving during ACCESS or RESP wait; none are lost, because req is level.
- A req bit dropping before its done is a protocol violation. The latched access still completes normally.
- sc_ready seen in IDLE or RESP is ignored.
- Reset asserted mid-ACCESS: strobes drop asynchronously, no done is issued, and the pending requester re-arbitrates after reset.
- Outputs grant, done, err, rdata and the sc_* signals are registered or decoded purely from registered state; there is no combinational path from req to grant.

Decomposition:
- systolic_array_pkg holds word_t and the new arb_state_t {IDLE, ACCESS, RESP}.
- One natural sub-module: rr_picker, a combinational round-robin first-set-bit finder that takes req and rr_ptr and returns the index plus a valid flag.

Test Plan:
- Single read: req[2]=1, addr 0x40, sc_ready 3 cycles after grant, sc_rdata 0xDEADBEEF → sc_read_en high 3 cycles with sc_addr 0x40; done[2] next cycle with rdata 0xDEADBEEF, err=0.
- Write: req[1]=1, we=1, addr 0x10, wdata 0x1234 → sc_write_en=1, sc_addr 0x10, sc_wdata 0x1234 until sc_ready; done[1] once.
- Round-robin, HOST_PRIO=0, req=4'b1111 held continuously → grant order 0,1,2,3,0, one per access, no requester skipped.
- Host priority, HOST_PRIO=1: req[3] and req[0] both pending, then req[0] re-asserted → host served first; requester 3 is served before requesters 1 and 2 on the next non-host pick.
- Timeout, TIMEOUT=8, sc_ready never asserted → strobe high exactly 8 cycles; then done with err=1 and rdata=0; the next requester is then granted.
- Reset mid-ACCESS: n_rst low during a write → sc_write_en=0 immediately, no done; after release requester 0 is granted first.

Source files
------------

// File: rtl/systolic_array_pkg.sv
// Shared types for the systolic-array scratchpad slice.
//
// Contents:
//   WORD_W      - scratchpad word width in bits
//   word_t      - one scratchpad word / word address
//   arb_state_t - scratchpad arbiter phase: IDLE, ACCESS, RESP
package systolic_array_pkg;

    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_t;

endpackage

// File: rtl/scratchpad_arbiter_rr_picker.sv
// rr_picker: combinational round-robin first-set-bit finder.
//
// Scans the request vector starting one position after the round-robin
// pointer and wrapping modulo NREQ. It returns the first requester found.
//
// Ports:
//   i_req      - per-requester request bits
//   i_rr_ptr   - index of the most recently served requester
//   o_idx      - index of the winning requester (0 when none)
//   o_valid    - high when at least one request bit is set
module rr_picker #(
    parameter int NREQ = 4,
    parameter int IDXW = 2
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IDXW-1:0] i_rr_ptr,
    output logic [IDXW-1:0] o_idx,
    output logic            o_valid
);

    // The loop walks from the farthest candidate back to the nearest one.
    // The last hit therefore lands on the requester closest after i_rr_ptr,
    // which avoids a loop break or a priority chain.
    always_comb begin
        o_idx   = '0;
        o_valid = 1'b0;
        for (int k = NREQ; k >= 1; k--) begin
            if (i_req[(int'(i_rr_ptr) + k) % NREQ]) begin
                o_idx   = IDXW'((int'(i_rr_ptr) + k) % NREQ);
                o_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/scratchpad_arbiter.sv
// scratchpad_arbiter: shares the single-port scratchpad between NREQ
// requesters. Requester 0 is the host. The others are the operand fetcher,
// the weight fetcher and the output writeback.
//
// Operation:
//   IDLE   - pick a winner and latch its command
//   ACCESS - drive the scratchpad strobe until sc_ready or a watchdog abort
//   RESP   - emit a one-cycle done pulse (with err) to the winner
//
// Ports:
//   clk, n_rst              - clock, asynchronous active-low reset
//   req/req_we              - per-requester level request and write flag
//   req_addr/req_wdata      - per-requester address and write data
//   grant                   - one-hot, high for the owner's whole ACCESS phase
//   done, err, rdata        - one-cycle completion, abort flag, read data
//   sc_read_en/sc_write_en  - scratchpad strobes
//   sc_addr/sc_wdata        - latched address and write data
//   sc_rdata/sc_ready       - scratchpad read data and completion
module scratchpad_arbiter
    import systolic_array_pkg::*;
#(
    parameter int NREQ      = 4,
    parameter int HOST_PRIO = 1,
    parameter int TIMEOUT   = 255
) (
    input  logic                         clk,
    input  logic                         n_rst,
    input  logic [NREQ-1:0]              req,
    input  logic [NREQ-1:0]              req_we,
    input  logic [NREQ-1:0][WORD_W-1:0]  req_addr,
    input  logic [NREQ-1:0][WORD_W-1:0]  req_wdata,
    output logic [NREQ-1:0]              grant,
    output logic [NREQ-1:0]              done,
    output logic                         err,
    output logic [WORD_W-1:0]            rdata,
    output logic                         sc_read_en,
    output logic                         sc_write_en,
    output logic [WORD_W-1:0]            sc_addr,
    output logic [WORD_W-1:0]            sc_wdata,
    input  logic [WORD_W-1:0]            sc_rdata,
    input  logic                         sc_ready
);

    localparam int IDXW  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT - 1);
    localparam logic [IDXW-1:0]  PTR_INIT = IDXW'(NREQ - 1);

    arb_state_t        r_state;
    logic [IDXW-1:0]   r_idx;
    logic              r_we;
    word_t             r_addr;
    word_t             r_wdata;
    logic [IDXW-1:0]   r_rr_ptr;
    logic              r_host_ovr;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_err;
    word_t             r_rdata;

    logic [IDXW-1:0]   w_rr_idx;
    logic              w_rr_valid;
    logic              w_host_pick;
    logic [IDXW-1:0]   w_pick_idx;

    rr_picker #(
        .NREQ (NREQ),
        .IDXW (IDXW)
    ) u_rr_picker (
        .i_req    (req),
        .i_rr_ptr (r_rr_ptr),
        .o_idx    (w_rr_idx),
        .o_valid  (w_rr_valid)
    );

    // The host override bypasses the round-robin result. It is remembered
    // (r_host_ovr) so that host traffic leaves the fairness pointer alone.
    assign w_host_pick = (HOST_PRIO != 0) && req[0];
    assign w_pick_idx  = w_host_pick ? '0 : w_rr_idx;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state    <= IDLE;
            r_idx      <= '0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rr_ptr   <= PTR_INIT;
            r_host_ovr <= 1'b0;
            r_cnt      <= '0;
            r_err      <= 1'b0;
            r_rdata    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_cnt <= '0;
                    if (w_rr_valid) begin
                        r_idx      <= w_pick_idx;
                        r_we       <= req_we[w_pick_idx];
                        r_addr     <= req_addr[w_pick_idx];
                        r_wdata    <= req_wdata[w_pick_idx];
                        r_host_ovr <= w_host_pick;
                        r_state    <= ACCESS;
                    end
                end
                ACCESS: begin
                    r_cnt <= r_cnt + 1'b1;
                    // A same-cycle sc_ready beats the watchdog.
                    if (sc_ready) begin
                        r_rdata <= sc_rdata;
                        r_err   <= 1'b0;
                        r_state <= RESP;
                    end else if ((TIMEOUT != 0) && (r_cnt == TO_LAST)) begin
                        r_rdata <= '0;
                        r_err   <= 1'b1;
                        r_state <= RESP;
                    end
                end
                RESP: begin
                    if (!r_host_ovr) begin
                        r_rr_ptr <= r_idx;
                    end
                    r_cnt   <= '0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Every output is decoded from registered state only. There is no
    // combinational path from req to grant. Reset clears the strobes at once.
    always_comb begin
        grant = '0;
        done  = '0;
        if (r_state == ACCESS) begin
            grant[r_idx] = 1'b1;
        end
        if (r_state == RESP) begin
            done[r_idx] = 1'b1;
        end
    end

    assign err         = (r_state == RESP) && r_err;
    assign rdata       = r_rdata;
    assign sc_read_en  = (r_state == ACCESS) && !r_we;
    assign sc_write_en = (r_state == ACCESS) && r_we;
    assign sc_addr     = r_addr;
    assign sc_wdata    = r_wdata;

endmodule

// File: tb/tb_scratchpad_arbiter.sv
// Testbench for scratchpad_arbiter.
//
// Two instances are used:
//   dut_a - host priority on, TIMEOUT=8
//   dut_b - pure round-robin, TIMEOUT=255
// Inputs change on the falling edge and outputs are sampled on the falling
// edge, well away from the rising edge the design uses.
module tb_scratchpad_arbiter;

    logic clk;
    logic n_rst;

    logic [3:0]        a_req, a_we, a_grant, a_done;
    logic [3:0][31:0]  a_addr, a_wdata;
    logic              a_err, a_rd, a_wr, a_ready;
    logic [31:0]       a_rdata, a_scaddr, a_scwdata, a_scrdata;

    logic [3:0]        b_req, b_we, b_grant, b_done;
    logic [3:0][31:0]  b_addr, b_wdata;
    logic              b_err, b_rd, b_wr, b_ready;
    logic [31:0]       b_rdata, b_scaddr, b_scwdata, b_scrdata;

    int total = 0;
    int bad   = 0;

    scratchpad_arbiter #(.NREQ(4), .HOST_PRIO(1), .TIMEOUT(8)) dut_a (
        .clk(clk), .n_rst(n_rst),
        .req(a_req), .req_we(a_we), .req_addr(a_addr), .req_wdata(a_wdata),
        .grant(a_grant), .done(a_done), .err(a_err), .rdata(a_rdata),
        .sc_read_en(a_rd), .sc_write_en(a_wr), .sc_addr(a_scaddr),
        .sc_wdata(a_scwdata), .sc_rdata(a_scrdata), .sc_ready(a_ready)
    );

    scratchpad_arbiter #(.NREQ(4), .HOST_PRIO(0), .TIMEOUT(255)) dut_b (
        .clk(clk), .n_rst(n_rst),
        .req(b_req), .req_we(b_we), .req_addr(b_addr), .req_wdata(b_wdata),
        .grant(b_grant), .done(b_done), .err(b_err), .rdata(b_rdata),
        .sc_read_en(b_rd), .sc_write_en(b_wr), .sc_addr(b_scaddr),
        .sc_wdata(b_scwdata), .sc_rdata(b_scrdata), .sc_ready(b_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Wait up to 20 falling edges for a grant on dut_a.
    // g is left at 0 if the bound expires.
    task automatic a_wait_grant(output logic [3:0] g, output int c);
        g = 4'b0;
        c = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (|a_grant) begin
                g = a_grant;
                c = i;
                break;
            end
        end
    endtask

    task automatic b_wait_grant(output logic [3:0] g, output int c);
        g = 4'b0;
        c = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (|b_grant) begin
                g = b_grant;
                c = i;
                break;
            end
        end
    endtask

    // Answer the current access with sc_ready for one cycle.
    // Return what the response cycle shows.
    task automatic a_complete(input logic [31:0] rd, output logic [3:0] d,
                              output logic e, output logic [31:0] r);
        a_ready   = 1'b1;
        a_scrdata = rd;
        @(negedge clk);
        a_ready   = 1'b0;
        d = a_done;
        e = a_err;
        r = a_rdata;
    endtask

    task automatic b_complete(input logic [31:0] rd, output logic [3:0] d,
                              output logic e, output logic [31:0] r);
        b_ready   = 1'b1;
        b_scrdata = rd;
        @(negedge clk);
        b_ready   = 1'b0;
        d = b_done;
        e = b_err;
        r = b_rdata;
    endtask

    task automatic test_reset();
        n_rst = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (a_grant !== 4'b0) begin bad++; $display("FAIL reset_grant: got %b expected 0000", a_grant); end
        total++; if (a_done !== 4'b0) begin bad++; $display("FAIL reset_done: got %b expected 0000", a_done); end
        total++; if (a_err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b expected 0", a_err); end
        total++; if (a_rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata: got %h expected 0", a_rdata); end
        total++; if ({a_rd, a_wr} !== 2'b00) begin bad++; $display("FAIL reset_strobes: got %b expected 00", {a_rd, a_wr}); end
        total++; if ({b_grant, b_rd, b_wr} !== 6'b0) begin bad++; $display("FAIL reset_b_outputs: got %b expected 0", {b_grant, b_rd, b_wr}); end
        n_rst = 1'b1;
    endtask

    task automatic test_write();
        logic [3:0] g, d; logic e; logic [31:0] r; int c;
        @(negedge clk);
        a_req = 4'b0010; a_we = 4'b0010; a_addr[1] = 32'h10; a_wdata[1] = 32'h1234;
        a_wait_grant(g, c);
        total++; if (g !== 4'b0010 || c !== 1) begin bad++; $display("FAIL write_grant: got %b after %0d expected 0010 after 1", g, c); end
        for (int i = 0; i < 2; i++) begin
            total++; if ({a_wr, a_rd} !== 2'b10) begin bad++; $display("FAIL write_strobe: got wr/rd %b expected 10", {a_wr, a_rd}); end
            total++; if (a_scaddr !== 32'h10 || a_scwdata !== 32'h1234) begin bad++; $display("FAIL write_addr_data: got %h/%h expected 10/1234", a_scaddr, a_scwdata); end
            // Changes from the requester must not reach the latched access.
            a_addr[1] = 32'h99; a_wdata[1] = 32'h5555;
            if (i == 0) @(negedge clk);
        end
        a_complete(32'h0, d, e, r);
        total++; if (d !== 4'b0010 || e !== 1'b0) begin bad++; $display("FAIL write_done: got %b err %b expected 0010 err 0", d, e); end
        a_req = 4'b0; a_we = 4'b0;
        @(negedge clk);
        total++; if (a_done !== 4'b0 || a_wr !== 1'b0) begin bad++; $display("FAIL write_done_once: got done %b wr %b expected 0000 0", a_done, a_wr); end
    endtask

    task automatic test_single_read();
        logic [3:0] g, d; logic e; logic [31:0] r; int c;
        @(negedge clk);
        a_req = 4'b0100; a_we = 4'b0; a_addr[2] = 32'h40;
        a_wait_grant(g, c);
        total++; if (g !== 4'b0100) begin bad++; $display("FAIL read_grant: got %b expected 0100", g); end
        for (int i = 0; i < 3; i++) begin
            total++; if ({a_rd, a_wr} !== 2'b10 || a_scaddr !== 32'h40) begin bad++; $display("FAIL read_strobe_cycle%0d: got rd/wr %b addr %h expected 10 addr 40", i, {a_rd, a_wr}, a_scaddr); end
            if (i < 2) @(negedge clk);
        end
        a_complete(32'hDEADBEEF, d, e, r);
        total++; if (d !== 4'b0100 || e !== 1'b0) begin bad++; $display("FAIL read_done: got %b err %b expected 0100 err 0", d, e); end
        total++; if (r !== 32'hDEADBEEF) begin bad++; $display("FAIL read_rdata: got %h expected deadbeef", r); end
        total++; if (a_rd !== 1'b0 || a_grant !== 4'b0) begin bad++; $display("FAIL read_resp_idle: got rd %b grant %b expected 0 0000", a_rd, a_grant); end
        a_req = 4'b0;
        @(negedge clk);
    endtask

    task automatic test_host_priority();
        logic [3:0] g, d; logic e; logic [31:0] r; int c;
        logic [3:0] exp_order [5];
        exp_order = '{4'b0001, 4'b0001, 4'b1000, 4'b0010, 4'b0100};
        @(negedge clk);
        a_req = 4'b1001; a_we = 4'b0;
        for (int i = 0; i < 5; i++) begin
            a_wait_grant(g, c);
            total++; if (g !== exp_order[i]) begin bad++; $display("FAIL host_order%0d: got %b expected %b", i, g, exp_order[i]); end
            a_complete(32'hA0 + 32'(i), d, e, r);
            total++; if (d !== exp_order[i]) begin bad++; $display("FAIL host_done%0d: got %b expected %b", i, d, exp_order[i]); end
            // The host keeps req[0] for a second access. Requesters 1 and 2
            // then join once the host has left.
            if (i == 1) a_req = 4'b1110;
            else if (i >= 2) a_req = a_req & ~exp_order[i];
        end
        a_req = 4'b0;
    endtask

    task automatic test_timeout();
        logic [3:0] g, d; logic e; logic [31:0] r; int c, cnt; bit got;
        @(negedge clk);
        a_req = 4'b1010; a_we = 4'b0;
        cnt = 0; got = 0; d = 4'b0; e = 1'b0; r = 32'hX;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (a_rd) cnt++;
            if (|a_done) begin d = a_done; e = a_err; r = a_rdata; got = 1; break; end
        end
        total++; if (!got) begin bad++; $display("FAIL timeout_done_seen: got none expected done within 30 cycles"); end
        total++; if (cnt !== 8) begin bad++; $display("FAIL timeout_strobe_len: got %0d expected 8", cnt); end
        total++; if (d !== 4'b1000 || e !== 1'b1 || r !== 32'h0) begin bad++; $display("FAIL timeout_resp: got done %b err %b rdata %h expected 1000 1 0", d, e, r); end
        a_req = 4'b0010;
        a_wait_grant(g, c);
        total++; if (g !== 4'b0010) begin bad++; $display("FAIL timeout_next_grant: got %b expected 0010", g); end
        a_complete(32'h77, d, e, r);
        total++; if (d !== 4'b0010 || e !== 1'b0 || r !== 32'h77) begin bad++; $display("FAIL timeout_next_done: got %b err %b rdata %h expected 0010 0 77", d, e, r); end
        a_req = 4'b0;
        @(negedge clk);
    endtask

    task automatic test_round_robin();
        logic [3:0] g, d; logic e; logic [31:0] r; int c;
        logic [3:0] exp_order [5];
        exp_order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        @(negedge clk);
        b_req = 4'b1111; b_we = 4'b0;
        for (int i = 0; i < 5; i++) begin
            b_wait_grant(g, c);
            total++; if (g !== exp_order[i]) begin bad++; $display("FAIL rr_order%0d: got %b expected %b", i, g, exp_order[i]); end
            total++; if (c !== ((i == 0) ? 1 : 2)) begin bad++; $display("FAIL rr_latency%0d: got %0d expected %0d", i, c, (i == 0) ? 1 : 2); end
            b_complete(32'h100 + 32'(i), d, e, r);
            total++; if (d !== exp_order[i] || r !== 32'h100 + 32'(i)) begin bad++; $display("FAIL rr_done%0d: got %b rdata %h expected %b rdata %h", i, d, r, exp_order[i], 32'h100 + 32'(i)); end
        end
        b_req = 4'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_access();
        logic [3:0] g, d; logic e; logic [31:0] r; int c;
        @(negedge clk);
        b_req = 4'b0100; b_we = 4'b0100; b_addr[2] = 32'h20; b_wdata[2] = 32'hCAFE;
        b_wait_grant(g, c);
        total++; if (g !== 4'b0100 || b_wr !== 1'b1) begin bad++; $display("FAIL rst_pre_grant: got %b wr %b expected 0100 1", g, b_wr); end
        @(negedge clk);
        n_rst = 1'b0;
        #1;
        total++; if (b_wr !== 1'b0 || b_grant !== 4'b0) begin bad++; $display("FAIL rst_async_drop: got wr %b grant %b expected 0 0000", b_wr, b_grant); end
        @(negedge clk);
        total++; if (b_done !== 4'b0) begin bad++; $display("FAIL rst_no_done: got %b expected 0000", b_done); end
        b_req = 4'b0101;
        b_we  = 4'b0100;
        n_rst = 1'b1;
        b_wait_grant(g, c);
        total++; if (g !== 4'b0001) begin bad++; $display("FAIL rst_first_grant: got %b expected 0001", g); end
        b_complete(32'h5, d, e, r);
        total++; if (d !== 4'b0001) begin bad++; $display("FAIL rst_first_done: got %b expected 0001", d); end
        b_req = 4'b0100;
        b_wait_grant(g, c);
        total++; if (g !== 4'b0100 || b_wr !== 1'b1) begin bad++; $display("FAIL rst_retry_grant: got %b wr %b expected 0100 1", g, b_wr); end
        b_complete(32'h0, d, e, r);
        total++; if (d !== 4'b0100) begin bad++; $display("FAIL rst_retry_done: got %b expected 0100", d); end
        b_req = 4'b0;
    endtask

    initial begin
        a_req = '0; a_we = '0; a_addr = '0; a_wdata = '0; a_ready = 1'b0; a_scrdata = '0;
        b_req = '0; b_we = '0; b_addr = '0; b_wdata = '0; b_ready = 1'b0; b_scrdata = '0;
        test_reset();
        test_write();
        test_single_read();
        test_host_priority();
        test_timeout();
        test_round_robin();
        test_reset_mid_access();
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Backstop so the run always ends on its own.
    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish before 200000");
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule
